// File: rtl/reminder_timer.sv
// Reminder countdown: counts detected tick_in seconds down from a loaded period and holds alarm at zero.
// Build option REMINDER_TIMER_AUTORELOAD_EN: ack in ALARM restarts the countdown instead of going idle.
module reminder_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SEC_W         = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             load,
  input  logic [SEC_W-1:0] period,
  input  logic             cancel,
  input  logic             ack,
  output logic             alarm,
  output logic             busy,
  output logic [SEC_W-1:0] remaining
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [SEC_W-1:0] per_latched, per_nxt;
  logic [SEC_W-1:0] rem_nxt;
  logic             alarm_nxt, busy_nxt;

  logic sync1, sync2, sync3;
  logic fill1, fill2, armed;
  logic tick;

  // fill1/fill2 mark when sync2 holds a real sample; a tick is only accepted after a genuine low
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= tick_in;
      sync2 <= sync1;
      sync3 <= sync2;
      fill1 <= 1'b1;
      fill2 <= fill1;
      if (fill2 && !sync2) armed <= 1'b1;
    end
  end

  assign tick = armed & sync2 & ~sync3;

  logic do_ack, do_tick, sec_done, last_sec;
  always_comb begin
    do_ack   = ack && (state == ALARM);
    do_tick  = tick && (state == COUNT);
    sec_done = (sub == SUB_MAX);
    last_sec = (remaining == SEC_W'(1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sub         <= '0;
      per_latched <= '0;
      remaining   <= '0;
      alarm       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sub         <= sub_nxt;
      per_latched <= per_nxt;
      remaining   <= rem_nxt;
      alarm       <= alarm_nxt;
      busy        <= busy_nxt;
    end
  end

  // Priority: cancel > load > ack > tick
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else if (load) begin
      state_nxt = (period != '0) ? COUNT : IDLE;
    end else if (do_ack) begin
`ifdef REMINDER_TIMER_AUTORELOAD_EN
      state_nxt = COUNT;
`else
      state_nxt = IDLE;
`endif
    end else if (do_tick && sec_done && last_sec) begin
      state_nxt = ALARM;
    end
  end

  always_comb begin
    sub_nxt = sub;
    rem_nxt = remaining;
    per_nxt = per_latched;
    if (cancel) begin
      sub_nxt = '0;
      rem_nxt = '0;
    end else if (load) begin
      sub_nxt = '0;
      if (period != '0) begin
        rem_nxt = period;
        per_nxt = period;
      end else begin
        rem_nxt = '0;
      end
    end else if (do_ack) begin
      sub_nxt = '0;
`ifdef REMINDER_TIMER_AUTORELOAD_EN
      rem_nxt = per_latched;
`else
      rem_nxt = '0;
`endif
    end else if (do_tick) begin
      if (sec_done) begin
        sub_nxt = '0;
        rem_nxt = remaining - 1'b1;
      end else begin
        sub_nxt = sub + 1'b1;
      end
    end
    alarm_nxt = (state_nxt == ALARM);
    busy_nxt  = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_reminder_timer.sv
// Bench for reminder_timer at TICKS_PER_SEC=4: vector table, directed corner sequences and a random run
// compared every cycle against a model that counts elapsed ticks since the last load.
module tb_reminder_timer;
  localparam int T     = 4;
  localparam int SEC_W = 17;
`ifdef REMINDER_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic             clock   = 1'b0;
  logic             reset   = 1'b1;
  logic             tick_in = 1'b0;
  logic             load    = 1'b0;
  logic             cancel  = 1'b0;
  logic             ack     = 1'b0;
  logic [SEC_W-1:0] period  = '0;
  logic             alarm, busy;
  logic [SEC_W-1:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  reminder_timer #(.TICKS_PER_SEC(T), .SEC_W(SEC_W)) dut (
    .clock(clock), .reset(reset), .tick_in(tick_in), .load(load), .period(period),
    .cancel(cancel), .ack(ack), .alarm(alarm), .busy(busy), .remaining(remaining)
  );

  always #5 clock = ~clock;

  // Model: 0 idle, 1 counting, 2 alarm; remaining derived from elapsed ticks.
  int m_mode = 0, m_per = 0, m_elapsed = 0, m_edges = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tk;
    m_edges++;
    // a tick is a rise between two real post-reset samples, seen 2 edges later
    tk = (m_edges >= 4) && h2 && !h3;
    h3 = h2; h2 = h1; h1 = tick_in;
    if (cancel) m_mode = 0;
    else if (load) begin
      if (period != 0) begin m_mode = 1; m_per = int'(period); m_elapsed = 0; end
      else m_mode = 0;
    end else if (ack && m_mode == 2) begin
      if (AR) begin m_mode = 1; m_elapsed = 0; end
      else m_mode = 0;
    end else if (tk && m_mode == 1) begin
      m_elapsed++;
      if (m_elapsed == m_per * T) m_mode = 2;
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    check("model alarm", int'(alarm), (m_mode == 2) ? 1 : 0);
    check("model busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("model remaining", int'(remaining), (m_mode == 1) ? (m_per - m_elapsed / T) : 0);
  endtask

  task automatic do_reset(input bit tin);
    tick_in = tin; load = 0; cancel = 0; ack = 0;
    #2 reset = 1'b1;
    m_mode = 0; m_per = 0; m_elapsed = 0; m_edges = 0; h1 = 0; h2 = 0; h3 = 0;
    #1;
    check("async reset alarm", int'(alarm), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset remaining", int'(remaining), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse(input bit c, input bit l, input bit a, input int p);
    cancel = c; load = l; ack = a; period = SEC_W'(p);
    step();
    cancel = 0; load = 0; ack = 0;
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      tick_in = 1; step(); step();
      tick_in = 0; step(); step();
    end
  endtask

  task automatic expect_out(input string nm, input int ea, input int eb, input int er);
    check({nm, " alarm"}, int'(alarm), ea);
    check({nm, " busy"}, int'(busy), eb);
    check({nm, " remaining"}, int'(remaining), er);
  endtask

  typedef struct {
    bit    c, l, a;
    int    p, nt;
    int    ea, eb, er;
    string nm;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 0, 3, 0, 0, 1, 3, "load3"};
    tbl[1] = '{0, 0, 0, 0, 4, 0, 1, 2, "4 ticks"};
    tbl[2] = '{0, 0, 0, 0, 4, 0, 1, 1, "8 ticks"};
    tbl[3] = '{0, 0, 0, 0, 3, 0, 1, 1, "11 ticks"};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 1, 0, "12th tick"};
    tbl[5] = '{0, 0, 0, 0, 2, 1, 1, 0, "ticks in alarm"};
    tbl[6] = '{0, 0, 1, 0, 0, 0, AR ? 1 : 0, AR ? 3 : 0, "ack"};
    tbl[7] = '{0, 0, 1, 0, 0, 0, AR ? 1 : 0, AR ? 3 : 0, "ack no alarm"};

    do_reset(1'b0);
    expect_out("reset", 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].c || tbl[i].l || tbl[i].a) pulse(tbl[i].c, tbl[i].l, tbl[i].a, tbl[i].p);
      ticks(tbl[i].nt);
      expect_out(tbl[i].nm, tbl[i].ea, tbl[i].eb, tbl[i].er);
    end

    // cancel beats load and ack in ALARM; load drops a coincident tick
    do_reset(1'b0);
    pulse(0, 1, 0, 1);
    ticks(4);
    expect_out("alarm before prio", 1, 1, 0);
    pulse(1, 1, 1, 5);
    expect_out("cancel+load+ack", 0, 0, 0);
    pulse(0, 1, 0, 7);
    tick_in = 1; step(); step();
    pulse(0, 1, 0, 5);
    step(); tick_in = 0; step(); step();
    expect_out("load with tick", 0, 1, 5);
    ticks(3);
    expect_out("tick dropped", 0, 1, 5);
    ticks(1);
    expect_out("first second", 0, 1, 4);

    // restart mid-count
    do_reset(1'b0);
    pulse(0, 1, 0, 10);
    ticks(6);
    expect_out("before restart", 0, 1, 9);
    pulse(0, 1, 0, 2);
    expect_out("restart", 0, 1, 2);
    ticks(7);
    expect_out("restart 7 ticks", 0, 1, 1);
    ticks(1);
    expect_out("restart expiry", 1, 1, 0);

    // tick_in high through reset release must not count
    do_reset(1'b1);
    repeat (3) step();
    pulse(0, 1, 0, 1);
    repeat (6) step();
    expect_out("high after reset", 0, 1, 1);
    tick_in = 0; step(); step();
    ticks(3);
    expect_out("3 real ticks", 0, 1, 1);
    ticks(1);
    expect_out("4 real ticks", 1, 1, 0);
    pulse(0, 1, 0, 3);
    ticks(2);
    expect_out("mid count", 0, 1, 3);
    do_reset(1'b0);

    // zero period
    pulse(0, 1, 0, 0);
    expect_out("load0 idle", 0, 0, 0);
    pulse(0, 1, 0, 3);
    ticks(2);
    pulse(0, 1, 0, 0);
    expect_out("load0 count", 0, 0, 0);

    // random traffic against the model
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      cancel = ($urandom_range(0, 149) == 0);
      load   = ($urandom_range(0, 59) == 0);
      period = SEC_W'($urandom_range(0, 3));
      ack    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      step();
    end
    cancel = 0; load = 0; ack = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reminder_timer.md
REMINDER_TIMER -- requirements
Module: reminder_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, number of tick_in rising edges per second (>=1).
REQ-002 SHALL have parameter SEC_W, default 17, width of second counters (86399 s = 24 h fits).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on posedge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick_in  input  1  divided-clock square wave from the divider, asynchronous to this block's sampling.
REQ-006 SHALL have port load  input  1  one-cycle pulse: start or restart countdown from period.
REQ-007 SHALL have port period  input  SEC_W  countdown length in seconds, sampled only when load=1.
REQ-008 SHALL have port cancel  input  1  one-cycle pulse: abort and go idle.
REQ-009 SHALL have port ack  input  1  one-cycle pulse: acknowledge an alarm.
REQ-010 SHALL have port alarm  output  1  high from expiry until acknowledged, cancelled or reloaded.
REQ-011 SHALL have port busy  output  1  high in COUNT or ALARM.
REQ-012 SHALL have port remaining  output  SEC_W  seconds left in current countdown.

Function
REQ-013 SHALL synchronise tick_in through two flops, then register the result once more; a tick is a 0->1 transition between the last two stages (one-cycle pulse, 3 cycles after tick_in rises).
REQ-014 SHALL implement states IDLE, COUNT, ALARM, with a sub-second counter sub (0..TICKS_PER_SEC-1) and a latched copy of period.
REQ-015 SHALL, in IDLE, on load with period!=0: latch period, remaining<=period, sub<=0, go COUNT; load with period==0 SHALL be ignored.
REQ-016 SHALL, in COUNT, on each tick: if sub==TICKS_PER_SEC-1 then sub<=0 and remaining<=remaining-1, else sub<=sub+1.
REQ-017 SHALL, in COUNT, when remaining decrements 1->0: go ALARM and assert alarm in the same clock edge.
REQ-018 SHALL, in ALARM, ignore ticks (sub held at 0, remaining held at 0).
REQ-019 SHALL, on ack in ALARM, deassert alarm next edge; ack in IDLE or COUNT SHALL have no effect.
REQ-020 SHALL treat load in COUNT or ALARM as restart: period!=0 -> COUNT with new period, sub<=0, alarm<=0; period==0 -> IDLE.
REQ-021 SHALL, on cancel in any state, go IDLE, remaining<=0, sub<=0, alarm<=0.
REQ-022 SHALL prioritise simultaneous events: cancel > load > ack > tick; the lower-priority event is dropped.
REQ-023 SHALL drive busy=1 exactly in COUNT and ALARM, all outputs registered.

Reset
REQ-024 SHALL, on reset=1, immediately go IDLE with alarm=0, busy=0, remaining=0, sub=0, latched period=0, synchroniser flops=0.
REQ-025 SHALL, after reset release, not count a tick unless tick_in is observed low then high (no spurious tick if tick_in is already high).
REQ-026 SHALL abort any countdown or pending alarm when reset asserts mid-operation.

Configuration
REQ-027 SHALL honour macro REMINDER_TIMER_AUTORELOAD_EN: when defined, ack in ALARM reloads remaining<=latched period, sub<=0, and returns to COUNT (repeating reminder).
REQ-028 SHALL, without REMINDER_TIMER_AUTORELOAD_EN, on ack in ALARM return to IDLE with remaining=0.

Verification (TICKS_PER_SEC=4)
REQ-029 SHALL verify basic count: load, period=3, 12 tick_in pulses -> remaining 3,2,1,0 every 4 ticks; alarm=1 on the 12th detected tick, busy=1 throughout.
REQ-030 SHALL verify ack: alarm high, ack pulse -> alarm=0 next edge; with AUTORELOAD_EN state=COUNT, remaining=3; without, state=IDLE, remaining=0, busy=0.
REQ-031 SHALL verify priority: cancel, load (period=5) and ack in one cycle during ALARM -> IDLE, alarm=0, remaining=0; load with period=5 and tick in same cycle -> remaining=5, sub=0.
REQ-032 SHALL verify restart: load period=10, 6 ticks, load period=2 -> remaining=2, sub=0; 8 more ticks -> alarm=1.
REQ-033 SHALL verify reset: tick_in held high across reset release, load period=1 -> no tick counted until tick_in goes low then high; async reset mid-COUNT clears outputs without a clock edge.
REQ-034 SHALL verify period==0: load with period=0 in IDLE -> stays IDLE; in COUNT -> IDLE, busy=0.
